// File: rtl/sr_cmd_seq.sv
// -----------------------------------------------------------------------------
// sr_cmd_seq
//
// Command sequencer feeding the 2-bit sr input of an SR flip-flop stage.
// Set/reset/nop commands arrive over a valid/ready handshake and are buffered
// in a small circular FIFO. Each popped command is driven on sr for HOLD
// cycles from a register, followed by GAP idle (2'b00) cycles. A shadow of
// the flip-flop's q level is kept in `level`.
//
// Build option:
//   SR_CMD_ILLEGAL_CHECK_EN  - when defined, an accepted 2'b11 command is
//                              consumed but dropped, and sets sticky `err`.
//                              When undefined, 2'b11 is queued as a nop and
//                              `err` is tied low.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   HOLD   cycles each popped code is driven on sr (>= 1)
//   GAP    idle cycles of 2'b00 after each command (>= 0)
//
// Ports:
//   clk       clock, all state changes on posedge
//   rst       asynchronous active-high reset
//   in_cmd    command: 00 nop, 01 reset, 10 set, 11 illegal
//   in_valid  in_cmd valid this cycle
//   in_ready  FIFO can accept (count != DEPTH)
//   sr        registered SR code, only 00/01/10
//   level     expected q of the downstream flip-flop
//   busy      sequencer active or FIFO non-empty
//   count     current FIFO occupancy
//   err       sticky illegal-command flag
// -----------------------------------------------------------------------------
module sr_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 1,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               in_cmd,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [1:0]               sr,
    output logic                     level,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD - 1);
    localparam logic [GW-1:0] GAP_LD   = GW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [HW-1:0]   hold_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            first;     // set during the first DRIVE cycle of a command
    logic            push;
    logic            enq;
    logic            pop;
    logic [1:0]      wr_data;
    logic [1:0]      head;

    assign in_ready = (count != FULL);
    assign busy     = (state != S_IDLE) || (count != '0);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && (count != '0);
    assign head     = mem[rd_ptr];

    // An illegal code is either dropped or stored as a nop, so the FIFO can
    // never hold 2'b11 and sr cannot carry it.
    assign wr_data  = (in_cmd == 2'b11) ? 2'b00 : in_cmd;

    always_comb begin
        enq = push;
`ifdef SR_CMD_ILLEGAL_CHECK_EN
        if (in_cmd == 2'b11) begin
            enq = 1'b0;
        end
`endif
    end

    // FIFO storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sr       <= 2'b00;
            level    <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            first    <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            case (state)
                S_IDLE: begin
                    sr <= 2'b00;
                    if (pop) begin
                        sr       <= head;
                        hold_cnt <= HOLD_LD;
                        first    <= 1'b1;
                        state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    // The flip-flop samples the code at the end of the first
                    // drive cycle, so the shadow level follows on that edge.
                    if (first) begin
                        first <= 1'b0;
                        if (sr == 2'b01) begin
                            level <= 1'b0;
                        end else if (sr == 2'b10) begin
                            level <= 1'b1;
                        end
                    end
                    if (hold_cnt == '0) begin
                        sr <= 2'b00;
                        if (GAP == 0) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= GAP_LD;
                            state   <= S_GAP;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                S_GAP: begin
                    sr <= 2'b00;
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    sr    <= 2'b00;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SR_CMD_ILLEGAL_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (push && (in_cmd == 2'b11)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
